// File: rtl/alocador_vozes_if.sv
// Keyboard-to-voice bus: key levels in, per-voice key/gate/load strobes out.
interface alocador_vozes_if #(
    parameter int N_KEYS   = 10,
    parameter int N_VOICES = 4,
    parameter int KEY_W    = 4
);
    logic [N_KEYS-1:0]         teclas;
    logic [N_VOICES*KEY_W-1:0] voice_key;
    logic [N_VOICES-1:0]       voice_gate;
    logic [N_VOICES-1:0]       voice_load;
    logic                      steal;
    logic [3:0]                n_active;

    modport master (input teclas, output voice_key, voice_gate, voice_load, steal, n_active);
    modport slave  (output teclas, input voice_key, voice_gate, voice_load, steal, n_active);
endinterface

// File: rtl/alocador_vozes.sv
// Polyphonic voice allocator: scans one key per cycle, assigns presses to free
// voices (or steals the oldest), and releases the voice holding a released key.
module alocador_voz #(
    parameter int KEY_W   = 4,
    parameter int AGE_W   = 3,
    parameter int AGE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             rel,
    input  logic             bump,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key,
    output logic             gate,
    output logic             load,
    output logic [AGE_W-1:0] age
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key  <= '0;
            gate <= 1'b0;
            load <= 1'b0;
            age  <= '0;
        end else if (sel) begin
            key  <= key_in;
            gate <= 1'b1;
            load <= 1'b1;
            age  <= '0;
        end else begin
            load <= 1'b0;
            if (rel) gate <= 1'b0;
            // key is kept on release so the release tail keeps its pitch
            if (bump && gate && age != AGE_W'(AGE_MAX)) age <= age + 1'b1;
        end
    end
endmodule

module alocador_vozes #(
    parameter int N_KEYS   = 10,
    parameter int N_VOICES = 4,
    parameter int KEY_W    = 4
) (
    input logic              clk,
    input logic              rst_n,
    alocador_vozes_if.master vif
);
    localparam int AGE_W = 3;

    logic [N_KEYS-1:0]                   key_meta, key_sync, key_prev, prev_nxt;
    logic [KEY_W-1:0]                    scan_idx;
    logic [N_VOICES-1:0][KEY_W-1:0]      vkey;
    logic [N_VOICES-1:0][AGE_W-1:0]      age;
    logic [N_VOICES-1:0]                 gate, load, sel, rel, gate_nxt;
    logic [N_VOICES-1:0]                 free_oh, old_oh;
    logic [AGE_W-1:0]                    old_age;
    logic                                k, p, press, rls, free_hit, steal_nxt;
    logic                                steal_q;
    logic [3:0]                          cnt_nxt, n_active_q;

    always_comb begin
        k        = 1'b0;
        p        = 1'b0;
        prev_nxt = key_prev;
        for (int i = 0; i < N_KEYS; i++) begin
            if (scan_idx == KEY_W'(i)) begin
                k           = key_sync[i];
                p           = key_prev[i];
                prev_nxt[i] = key_sync[i];
            end
        end
        press = k & ~p;
        rls   = ~k & p;

        free_hit = 1'b0;
        free_oh  = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (!gate[v] && !free_hit) begin
                free_hit   = 1'b1;
                free_oh[v] = 1'b1;
            end
        end
        // strict compare keeps ties on the lowest index
        old_oh    = '0;
        old_oh[0] = 1'b1;
        old_age   = age[0];
        for (int v = 1; v < N_VOICES; v++) begin
            if (age[v] > old_age) begin
                old_age   = age[v];
                old_oh    = '0;
                old_oh[v] = 1'b1;
            end
        end

        sel       = '0;
        steal_nxt = 1'b0;
        if (press) begin
            if (free_hit) begin
                sel = free_oh;
            end else begin
                sel       = old_oh;
                steal_nxt = 1'b1;
            end
        end
        rel = '0;
        if (rls) begin
            for (int v = 0; v < N_VOICES; v++)
                if (gate[v] && vkey[v] == scan_idx) rel[v] = 1'b1;
        end

        gate_nxt = (gate & ~rel) | sel;
        cnt_nxt  = '0;
        for (int v = 0; v < N_VOICES; v++) cnt_nxt = cnt_nxt + {3'b000, gate_nxt[v]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta   <= '0;
            key_sync   <= '0;
            key_prev   <= '0;
            scan_idx   <= '0;
            steal_q    <= 1'b0;
            n_active_q <= '0;
        end else begin
            key_meta   <= vif.teclas;
            key_sync   <= key_meta;
            key_prev   <= prev_nxt;
            scan_idx   <= (scan_idx == KEY_W'(N_KEYS-1)) ? '0 : scan_idx + 1'b1;
            steal_q    <= steal_nxt;
            n_active_q <= cnt_nxt;
        end
    end

    for (genvar v = 0; v < N_VOICES; v++) begin : g_voz
        alocador_voz #(.KEY_W(KEY_W), .AGE_W(AGE_W), .AGE_MAX(N_VOICES-1)) u_voz (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel    (sel[v]),
            .rel    (rel[v]),
            .bump   (press),
            .key_in (scan_idx),
            .key    (vkey[v]),
            .gate   (gate[v]),
            .load   (load[v]),
            .age    (age[v])
        );
    end

    assign vif.voice_key  = vkey;
    assign vif.voice_gate = gate;
    assign vif.voice_load = load;
    assign vif.steal      = steal_q;
    assign vif.n_active   = n_active_q;
endmodule

// File: tb/tb_alocador_vozes.sv
// Directed bench for alocador_vozes: allocation order, stealing, release, glitch rejection, reset.
module tb_alocador_vozes;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alocador_vozes_if vif ();
    alocador_vozes dut (.clk(clk), .rst_n(rst_n), .vif(vif));

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    int n_steal = 0;
    logic [3:0] q_mask[$];
    logic [3:0] q_key[$];

    // cyc mirrors the scan position: after cyc edges out of reset, scan = cyc mod 10
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && vif.voice_load != 4'b0000) begin
            logic [3:0] kk;
            kk = 4'h0;
            for (int v = 3; v >= 0; v--)
                if (vif.voice_load[v]) kk = vif.voice_key[v*4 +: 4];
            q_mask.push_back(vif.voice_load);
            q_key.push_back(kk);
        end
        if (rst_n && vif.steal) n_steal++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // return just after the edge that leaves scan_idx at 8, so new keys are seen in one ordered pass
    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 10 != 8);
    endtask

    task automatic chk_load(input string tag, input int idx, input logic [3:0] m, input logic [3:0] kk);
        if (q_mask.size() > idx) begin
            chk({tag, "_mask"}, q_mask[idx], m);
            chk({tag, "_key"}, q_key[idx], kk);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        int base;
        int sbase;
        int lat;
        vif.teclas = 10'b0;
        tick(3);
        chk("rst_gate", vif.voice_gate, 4'b0000);
        chk("rst_load", vif.voice_load, 4'b0000);
        chk("rst_key", vif.voice_key, 16'h0000);
        chk("rst_steal", vif.steal, 1'b0);
        chk("rst_nact", vif.n_active, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);

        // 1: single key 3
        base = q_mask.size();
        sbase = n_steal;
        vif.teclas = 10'b0000001000;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vif.voice_gate[0] === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("t1_latency", (lat >= 1 && lat <= 12), 1);
        tick(14);
        chk("t1_nloads", q_mask.size() - base, 1);
        chk_load("t1_load", base, 4'b0001, 4'd3);
        chk("t1_gate", vif.voice_gate, 4'b0001);
        chk("t1_key0", vif.voice_key[3:0], 4'd3);
        chk("t1_nact", vif.n_active, 4'd1);
        vif.teclas = 10'b0;
        tick(14);
        chk("t1_rel_gate", vif.voice_gate, 4'b0000);
        chk("t1_rel_key0", vif.voice_key[3:0], 4'd3);
        chk("t1_rel_nact", vif.n_active, 4'd0);

        // 2: keys 1,2,5 together
        align();
        base = q_mask.size();
        vif.teclas = 10'b0000100110;
        tick(14);
        chk("t2_nloads", q_mask.size() - base, 3);
        chk_load("t2_l0", base, 4'b0001, 4'd1);
        chk_load("t2_l1", base + 1, 4'b0010, 4'd2);
        chk_load("t2_l2", base + 2, 4'b0100, 4'd5);
        chk("t2_keys", vif.voice_key[11:0], 12'h521);
        chk("t2_gate", vif.voice_gate, 4'b0111);
        chk("t2_nact", vif.n_active, 4'd3);
        chk("t2_steal", n_steal - sbase, 0);

        // 3: fill with 0..3 then steal with 7
        vif.teclas = 10'b0;
        tick(14);
        chk("t3_clear", vif.voice_gate, 4'b0000);
        align();
        vif.teclas = 10'b0000001111;
        tick(14);
        chk("t3_full_gate", vif.voice_gate, 4'b1111);
        chk("t3_full_keys", vif.voice_key, 16'h3210);
        chk("t3_full_nact", vif.n_active, 4'd4);
        align();
        base = q_mask.size();
        sbase = n_steal;
        vif.teclas = 10'b0010001111;
        tick(14);
        chk("t3_steal", n_steal - sbase, 1);
        chk("t3_nloads", q_mask.size() - base, 1);
        chk_load("t3_load", base, 4'b0001, 4'd7);
        chk("t3_keys", vif.voice_key, 16'h3217);
        chk("t3_gate", vif.voice_gate, 4'b1111);
        chk("t3_nact", vif.n_active, 4'd4);

        // 4: release stolen key 0 (no effect), then key 7
        base = q_mask.size();
        vif.teclas = 10'b0010001110;
        tick(14);
        chk("t4_stolen_gate", vif.voice_gate, 4'b1111);
        chk("t4_stolen_nact", vif.n_active, 4'd4);
        vif.teclas = 10'b0000001110;
        tick(14);
        chk("t4_rel_gate", vif.voice_gate, 4'b1110);
        chk("t4_rel_key0", vif.voice_key[3:0], 4'd7);
        chk("t4_rel_nact", vif.n_active, 4'd3);
        chk("t4_nloads", q_mask.size() - base, 0);

        // 5: short glitch on key 9 between scans, then a real press
        align();
        base = q_mask.size();
        sbase = n_steal;
        vif.teclas = 10'b1000001110;
        repeat (2) @(posedge clk);
        #1;
        vif.teclas = 10'b0000001110;
        tick(14);
        chk("t5_glitch_loads", q_mask.size() - base, 0);
        chk("t5_glitch_gate", vif.voice_gate, 4'b1110);
        chk("t5_glitch_steal", n_steal - sbase, 0);
        vif.teclas = 10'b1000001110;
        tick(30);
        chk("t5_nloads", q_mask.size() - base, 1);
        chk_load("t5_load", base, 4'b0001, 4'd9);
        chk("t5_gate", vif.voice_gate, 4'b1111);
        chk("t5_nact", vif.n_active, 4'd4);
        vif.teclas = 10'b0000001110;
        tick(14);
        chk("t5_rel_gate", vif.voice_gate, 4'b1110);
        chk("t5_rel_key0", vif.voice_key[3:0], 4'd9);
        chk("t5_rel_nact", vif.n_active, 4'd3);

        // 6: async reset with 3 voices gated, keys still held
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_gate", vif.voice_gate, 4'b0000);
        chk("t6_async_key", vif.voice_key, 16'h0000);
        chk("t6_async_nact", vif.n_active, 4'd0);
        chk("t6_async_load", vif.voice_load, 4'b0000);
        @(negedge clk);
        base = q_mask.size();
        sbase = n_steal;
        rst_n = 1'b1;
        tick(14);
        // key 1 is scanned before the synchronizer fills, so it lands last
        chk("t6_gate", vif.voice_gate, 4'b0111);
        chk("t6_keys", vif.voice_key[11:0], 12'h132);
        chk("t6_nact", vif.n_active, 4'd3);
        chk("t6_nloads", q_mask.size() - base, 3);
        chk("t6_steal", n_steal - sbase, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
